// File: rtl/score_row_reduce.sv
// Row reducer for streamed signed 8-bit score vectors: reports the row max, its column
// and a saturating sum through a two-stage pipeline (per-beat reduce, then row accumulate).
module score_row_reduce #(
  parameter int LANES = 16,
  parameter int COLW  = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*LANES-1:0]      in_vec,
  input  logic                    in_last,
  input  logic [11:0]             in_row,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [11:0]             out_row,
  output logic signed [7:0]       out_max,
  output logic [COLW-1:0]         out_col,
  output logic signed [15:0]      out_sum,
  output logic                    out_ovf
);

  localparam int LW = $clog2(LANES);
  localparam int BW = COLW - LW;
  localparam logic [BW-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, HOLD} state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [11:0]       row_q, row_d;
  logic              ovf_q, ovf_d;
  logic              accept;
  logic [BW-1:0]     beat_idx;

  logic signed [7:0]  lane_val;
  logic signed [7:0]  vec_max;
  logic [LW-1:0]      vec_lane;
  logic signed [15:0] vec_sum;

  logic               s1_valid_q, s1_first_q;
  logic signed [7:0]  s1_max_q;
  logic [COLW-1:0]    s1_col_q;
  logic signed [15:0] s1_sum_q;

  logic signed [7:0]  acc_max_q;
  logic [COLW-1:0]    acc_col_q;
  logic signed [15:0] acc_sum_q;
  logic signed [16:0] sum_wide;
  logic signed [15:0] sum_sat;

  // in_ready is kept out of the FSM process so accept does not loop back into it
  assign in_ready = !rst && (state_q == IDLE || state_q == ACCUM);
  assign accept   = in_valid && in_ready;
  assign beat_idx = (state_q == IDLE) ? '0 : beat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      row_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      row_q   <= row_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    row_d     = row_q;
    ovf_d     = ovf_q;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          row_d   = in_row;
          ovf_d   = 1'b0;
          beat_d  = BW'(1);
          state_d = in_last ? FLUSH : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          beat_d = beat_q + BW'(1);
          if (in_last) begin
            state_d = FLUSH;
          end else if (beat_q == LAST_BEAT) begin
            state_d = FLUSH;
            ovf_d   = 1'b1;
          end
        end
      end
      FLUSH: begin
        beat_d  = '0;
        state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strict greater-than keeps the lowest lane on ties
  always_comb begin
    vec_max  = $signed(in_vec[7:0]);
    vec_lane = '0;
    vec_sum  = {{8{in_vec[7]}}, in_vec[7:0]};
    lane_val = '0;
    for (int k = 1; k < LANES; k++) begin
      lane_val = $signed(in_vec[8*k +: 8]);
      if (lane_val > vec_max) begin
        vec_max  = lane_val;
        vec_lane = LW'(k);
      end
      vec_sum = vec_sum + {{8{lane_val[7]}}, lane_val};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_max_q   <= '0;
      s1_col_q   <= '0;
      s1_sum_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_first_q <= (state_q == IDLE);
        s1_max_q   <= vec_max;
        s1_col_q   <= {beat_idx, vec_lane};
        s1_sum_q   <= vec_sum;
      end
    end
  end

  always_comb begin
    sum_wide = {acc_sum_q[15], acc_sum_q} + {s1_sum_q[15], s1_sum_q};
    sum_sat  = sum_wide[15:0];
    if (sum_wide[16] != sum_wide[15]) sum_sat = sum_wide[16] ? 16'sh8000 : 16'sh7FFF;
  end

  // Beats arrive in column order, so a later beat only wins on a strictly larger max
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_max_q <= 8'sh80;
      acc_col_q <= '0;
      acc_sum_q <= '0;
    end else if (s1_valid_q) begin
      if (s1_first_q) begin
        acc_max_q <= s1_max_q;
        acc_col_q <= s1_col_q;
        acc_sum_q <= s1_sum_q;
      end else begin
        if (s1_max_q > acc_max_q) begin
          acc_max_q <= s1_max_q;
          acc_col_q <= s1_col_q;
        end
        acc_sum_q <= sum_sat;
      end
    end
  end

  assign out_row = row_q;
  assign out_max = acc_max_q;
  assign out_col = acc_col_q;
  assign out_sum = acc_sum_q;
  assign out_ovf = ovf_q;

endmodule
